// File: rtl/cache_pkg.sv
// Shared types for the data-cache miss controller: FSM states and the 4-byte line.
package cache_pkg;

    localparam int LINE_BYTES = 4;

    typedef logic [LINE_BYTES-1:0][7:0] line_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOOKUP    = 3'd1,
        ST_WRITEBACK = 3'd2,
        ST_REFILL    = 3'd3,
        ST_FILL      = 3'd4,
        ST_ALLOC     = 3'd5,
        ST_RESP      = 3'd6
    } state_e;

endpackage

// File: rtl/cache_ctrl.sv
// Miss-handling controller for a direct-mapped write-back cache with 4-byte lines.
// Sequences lookup, dirty-victim writeback, refill and the CPU response.
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int C_WIDTH = 13,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [XLEN-1:0]  cpu_addr,
    input  line_t            cpu_wdata,
    output logic             cpu_ready,
    output line_t            cpu_rdata,
    output logic [XLEN-1:0]  c_addr,
    output logic             c_we,
    output line_t            c_wdata,
    input  logic             c_hit,
    input  logic             c_dirty,
    input  logic [XLEN-1:0]  c_miss_addr,
    input  line_t            c_rdata,
    output logic             mem_req,
    output logic             mem_we,
    output logic [XLEN-1:0]  mem_addr,
    output line_t            mem_wdata,
    input  logic             mem_ack,
    input  line_t            mem_rdata,
    output logic [CNT_W-1:0] perf_hits,
    output logic [CNT_W-1:0] perf_misses,
    output logic [CNT_W-1:0] perf_wbs,
    output state_e           o_dbg_state
);

    // Memory handshake: mem_req and its qualifiers are held constant until the
    // cycle mem_ack is high; that clock edge completes the transfer. Ack may come
    // in the first request cycle. Acks outside WRITEBACK/REFILL are ignored.

    state_e            r_state;
    state_e            w_next_state;
    logic [XLEN-1:2]   r_addr;
    logic              r_we;
    line_t             r_wdata;
    logic [XLEN-1:C_WIDTH] r_victim_tag;
    line_t             r_victim_data;
    line_t             r_fill;
    line_t             r_resp;
    logic [CNT_W-1:0]  r_hits;
    logic [CNT_W-1:0]  r_misses;
    logic [CNT_W-1:0]  r_wbs;
    logic              w_hit_evt;
    logic              w_miss_evt;
    logic              w_wb_evt;
    logic              w_unused;

    // The victim shares the request's index, so only its tag needs to be kept.
    assign w_unused = &{1'b0, cpu_addr[1:0], c_miss_addr[C_WIDTH-1:0]};

    assign c_addr      = {r_addr, 2'b00};
    assign cpu_rdata   = r_resp;
    assign perf_hits   = r_hits;
    assign perf_misses = r_misses;
    assign perf_wbs    = r_wbs;
    assign o_dbg_state = r_state;

    always_comb begin
        w_next_state = r_state;
        cpu_ready    = 1'b0;
        c_we         = 1'b0;
        c_wdata      = '0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        w_hit_evt    = 1'b0;
        w_miss_evt   = 1'b0;
        w_wb_evt     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cpu_req) w_next_state = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                if (c_hit) begin
                    w_hit_evt    = 1'b1;
                    c_we         = r_we;
                    c_wdata      = r_we ? r_wdata : '0;
                    w_next_state = ST_RESP;
                end else begin
                    w_miss_evt = 1'b1;
                    if (c_dirty)   w_next_state = ST_WRITEBACK;
                    else if (r_we) w_next_state = ST_ALLOC;
                    else           w_next_state = ST_REFILL;
                end
            end
            ST_WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {r_victim_tag, r_addr[C_WIDTH-1:2], 2'b00};
                mem_wdata = r_victim_data;
                if (mem_ack) begin
                    w_wb_evt     = 1'b1;
                    w_next_state = r_we ? ST_ALLOC : ST_REFILL;
                end
            end
            ST_REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {r_addr, 2'b00};
                if (mem_ack) w_next_state = ST_FILL;
            end
            ST_FILL: begin
                c_we         = 1'b1;
                c_wdata      = r_fill;
                w_next_state = ST_RESP;
            end
            ST_ALLOC: begin
                // A store always covers the whole line, so no refill is needed.
                c_we         = 1'b1;
                c_wdata      = r_wdata;
                w_next_state = ST_RESP;
            end
            ST_RESP: begin
                cpu_ready    = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state       <= ST_IDLE;
            r_addr        <= '0;
            r_we          <= 1'b0;
            r_wdata       <= '0;
            r_victim_tag  <= '0;
            r_victim_data <= '0;
            r_fill        <= '0;
            r_resp        <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_IDLE && cpu_req) begin
                r_addr  <= cpu_addr[XLEN-1:2];
                r_we    <= cpu_we;
                r_wdata <= cpu_wdata;
            end
            if (r_state == ST_LOOKUP && c_hit && !r_we) r_resp <= c_rdata;
            if (r_state == ST_LOOKUP && !c_hit && c_dirty) begin
                r_victim_tag  <= c_miss_addr[XLEN-1:C_WIDTH];
                r_victim_data <= c_rdata;
            end
            if (r_state == ST_REFILL && mem_ack) r_fill <= mem_rdata;
            if (r_state == ST_FILL) r_resp <= r_fill;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_hits   <= '0;
            r_misses <= '0;
            r_wbs    <= '0;
        end else begin
            if (w_hit_evt)  r_hits   <= r_hits + CNT_W'(1);
            if (w_miss_evt) r_misses <= r_misses + CNT_W'(1);
            if (w_wb_evt)   r_wbs    <= r_wbs + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: directed vector table, hand-written corner sequences,
// and random transactions checked against a transaction-level reference model.
module tb_cache_ctrl;
    import cache_pkg::*;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr;
    line_t       cpu_wdata;
    logic        cpu_ready;
    line_t       cpu_rdata;
    logic [31:0] c_addr;
    logic        c_we;
    line_t       c_wdata;
    logic        c_hit, c_dirty;
    logic [31:0] c_miss_addr;
    line_t       c_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    line_t       mem_wdata;
    logic        mem_ack;
    line_t       mem_rdata;
    logic [15:0] perf_hits, perf_misses, perf_wbs;
    state_e      dbg_state;

    cache_ctrl #(.XLEN(32), .C_WIDTH(13), .CNT_W(16)) dut (
        .clk(clk), .rst_b(rst_b),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .c_addr(c_addr), .c_we(c_we), .c_wdata(c_wdata), .c_hit(c_hit), .c_dirty(c_dirty),
        .c_miss_addr(c_miss_addr), .c_rdata(c_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .perf_hits(perf_hits), .perf_misses(perf_misses), .perf_wbs(perf_wbs),
        .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [64:0] obs_mem_q[$];
    logic [64:0] exp_mem_q[$];
    logic [31:0] obs_cwe_q[$];
    logic [31:0] exp_cwe_q[$];
    int          exp_lat;
    line_t       exp_rdata;
    logic [15:0] m_hits, m_misses, m_wbs;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        line_t       wd;
        logic        hit;
        logic        dirty;
        logic [31:0] vaddr;
        line_t       cline;
        line_t       fill;
        int          wbd;
        int          rfd;
        int          e_lat;
        line_t       e_rdata;
        int          e_ncwe;
        line_t       e_cwe;
        int          e_nmem;
        logic [64:0] e_mem0;
        logic [15:0] e_hits;
        logic [15:0] e_misses;
        logic [15:0] e_wbs;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Issues one CPU request and plays cache array and main memory until cpu_ready.
    task automatic run_txn(input logic we, input logic [31:0] addr, input line_t wd,
                           input logic hit, input logic dirty, input logic [31:0] vaddr,
                           input line_t cline, input line_t fill, input int wbd, input int rfd,
                           output int lat, output line_t rdata);
        int          wait_cnt;
        logic        held;
        logic [64:0] cur;
        logic [64:0] prev;
        obs_mem_q.delete();
        obs_cwe_q.delete();
        wait_cnt = 0;
        held     = 1'b0;
        prev     = '0;
        lat      = -1;
        rdata    = '0;
        @(posedge clk); #1;
        c_hit       = hit;
        c_dirty     = dirty;
        c_miss_addr = vaddr;
        c_rdata     = cline;
        cpu_we      = we;
        cpu_addr    = addr;
        cpu_wdata   = wd;
        cpu_req     = 1'b1;
        @(posedge clk); #1;
        cpu_req   = 1'b0;
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = $urandom;
        cpu_wdata = $urandom;
        for (int cyc = 0; cyc <= 60; cyc++) begin
            mem_ack = 1'b0;
            if (c_we) begin
                obs_cwe_q.push_back(c_wdata);
                chk("c_addr", c_addr, {addr[31:2], 2'b00});
            end
            if (mem_req) begin
                cur = {mem_we, mem_addr, mem_wdata};
                if (held) chk("mem_hold", cur, prev);
                prev = cur;
                held = 1'b1;
                if (wait_cnt == (mem_we ? wbd : rfd)) begin
                    mem_ack   = 1'b1;
                    mem_rdata = fill;
                    obs_mem_q.push_back({mem_we, mem_addr, mem_we ? mem_wdata : 32'h0});
                    wait_cnt  = 0;
                    held      = 1'b0;
                end else begin
                    wait_cnt++;
                    mem_rdata = $urandom;
                end
            end else begin
                held = 1'b0;
            end
            if (cpu_ready) begin
                lat   = cyc;
                rdata = cpu_rdata;
                break;
            end
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
        if (lat < 0) chk("ready_timeout", 1'b0, 1'b1);
    endtask

    task automatic model(input logic we, input logic [31:0] addr, input line_t wd,
                         input logic hit, input logic dirty, input logic [31:0] vaddr,
                         input line_t cline, input line_t fill, input int wbd, input int rfd);
        exp_mem_q.delete();
        exp_cwe_q.delete();
        exp_rdata = '0;
        exp_lat   = 1;
        if (hit) begin
            m_hits++;
            if (we) exp_cwe_q.push_back(wd);
            else    exp_rdata = cline;
        end else begin
            m_misses++;
            if (dirty) begin
                exp_mem_q.push_back({1'b1, vaddr[31:2], 2'b00, cline});
                m_wbs++;
                exp_lat += wbd + 1;
            end
            if (we) begin
                exp_cwe_q.push_back(wd);
                exp_lat += 1;
            end else begin
                exp_mem_q.push_back({1'b0, addr[31:2], 2'b00, 32'h0});
                exp_cwe_q.push_back(fill);
                exp_rdata = fill;
                exp_lat += rfd + 2;
            end
        end
    endtask

    task automatic compare(input string tag, input logic we, input int lat, input line_t rdata);
        chk({tag, "_lat"}, lat, exp_lat);
        if (!we) chk({tag, "_rdata"}, rdata, exp_rdata);
        chk({tag, "_ncwe"}, obs_cwe_q.size(), exp_cwe_q.size());
        foreach (exp_cwe_q[k]) if (k < obs_cwe_q.size()) chk({tag, "_cwe"}, obs_cwe_q[k], exp_cwe_q[k]);
        chk({tag, "_nmem"}, obs_mem_q.size(), exp_mem_q.size());
        foreach (exp_mem_q[k]) if (k < obs_mem_q.size()) chk({tag, "_mem"}, obs_mem_q[k], exp_mem_q[k]);
        chk({tag, "_hits"}, perf_hits, m_hits);
        chk({tag, "_misses"}, perf_misses, m_misses);
        chk({tag, "_wbs"}, perf_wbs, m_wbs);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int          lat;
        line_t       rdata;
        logic        r_we, r_hit, r_dirty;
        logic [31:0] r_addr, r_vraw;
        line_t       r_wd, r_cline, r_fill;
        int          r_wbd, r_rfd;
        int          n_rdy;
        int          last;
        logic        seen;

        vecs[0] = '{1'b0, 32'h0000_1000, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h4433_2211, 0, 0,
                    3, 32'h4433_2211, 1, 32'h4433_2211, 1, {1'b0, 32'h0000_1000, 32'h0}, 16'd0, 16'd1, 16'd0};
        vecs[1] = '{1'b0, 32'h0000_1000, 32'h0, 1'b1, 1'b0, 32'h0, 32'h4433_2211, 32'h0, 0, 0,
                    1, 32'h4433_2211, 0, 32'h0, 0, 65'h0, 16'd1, 16'd1, 16'd0};
        vecs[2] = '{1'b1, 32'h0000_3000, 32'hDDCC_BBAA, 1'b0, 1'b1, 32'h0000_1000, 32'h0403_0201, 32'hDEAD_BEEF, 0, 0,
                    3, 32'h0, 1, 32'hDDCC_BBAA, 1, {1'b1, 32'h0000_1000, 32'h0403_0201}, 16'd1, 16'd2, 16'd1};
        vecs[3] = '{1'b0, 32'h0000_2006, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h8877_6655, 0, 5,
                    8, 32'h8877_6655, 1, 32'h8877_6655, 1, {1'b0, 32'h0000_2004, 32'h0}, 16'd1, 16'd3, 16'd1};
        vecs[4] = '{1'b1, 32'h0000_0010, 32'h1234_5678, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 0, 0,
                    1, 32'h0, 1, 32'h1234_5678, 0, 65'h0, 16'd2, 16'd3, 16'd1};
        vecs[5] = '{1'b0, 32'h0000_4008, 32'h0, 1'b0, 1'b1, 32'h0001_0008, 32'hA5A5_A5A5, 32'h0F0E_0D0C, 2, 1,
                    7, 32'h0F0E_0D0C, 1, 32'h0F0E_0D0C, 2, {1'b1, 32'h0001_0008, 32'hA5A5_A5A5}, 16'd2, 16'd4, 16'd2};

        rst_b = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        c_hit = 1'b0; c_dirty = 1'b0; c_miss_addr = '0; c_rdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        #23;
        chk("rst_state", dbg_state, ST_IDLE);
        chk("rst_cpu_ready", cpu_ready, 1'b0);
        chk("rst_c_we", c_we, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        chk("rst_c_wdata", c_wdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_hits", perf_hits, 16'd0);
        chk("rst_misses", perf_misses, 16'd0);
        chk("rst_wbs", perf_wbs, 16'd0);
        rst_b = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].hit, vecs[i].dirty, vecs[i].vaddr,
                    vecs[i].cline, vecs[i].fill, vecs[i].wbd, vecs[i].rfd, lat, rdata);
            chk($sformatf("vec%0d_lat", i), lat, vecs[i].e_lat);
            if (!vecs[i].we) chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].e_rdata);
            chk($sformatf("vec%0d_ncwe", i), obs_cwe_q.size(), vecs[i].e_ncwe);
            if (vecs[i].e_ncwe > 0 && obs_cwe_q.size() > 0)
                chk($sformatf("vec%0d_cwe", i), obs_cwe_q[0], vecs[i].e_cwe);
            chk($sformatf("vec%0d_nmem", i), obs_mem_q.size(), vecs[i].e_nmem);
            if (vecs[i].e_nmem > 0 && obs_mem_q.size() > 0)
                chk($sformatf("vec%0d_mem0", i), obs_mem_q[0], vecs[i].e_mem0);
            chk($sformatf("vec%0d_hits", i), perf_hits, vecs[i].e_hits);
            chk($sformatf("vec%0d_misses", i), perf_misses, vecs[i].e_misses);
            chk($sformatf("vec%0d_wbs", i), perf_wbs, vecs[i].e_wbs);
        end
        m_hits = 16'd2; m_misses = 16'd4; m_wbs = 16'd2;

        // Spurious acknowledges while idle must not disturb anything.
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            mem_ack   = 1'b1;
            mem_rdata = $urandom;
            @(posedge clk); #1;
            chk("spur_state", dbg_state, ST_IDLE);
            chk("spur_mem_req", mem_req, 1'b0);
            chk("spur_ready", cpu_ready, 1'b0);
            chk("spur_c_we", c_we, 1'b0);
        end
        mem_ack = 1'b0;
        chk("spur_hits", perf_hits, m_hits);
        chk("spur_misses", perf_misses, m_misses);
        chk("spur_wbs", perf_wbs, m_wbs);

        for (int t = 0; t < 40; t++) begin
            r_we    = 1'($urandom_range(0, 1));
            r_hit   = ($urandom_range(0, 2) == 0);
            r_dirty = 1'($urandom_range(0, 1));
            r_addr  = $urandom;
            r_vraw  = $urandom;
            r_wd    = $urandom;
            r_cline = $urandom;
            r_fill  = $urandom;
            r_wbd   = $urandom_range(0, 4);
            r_rfd   = $urandom_range(0, 4);
            r_vraw  = {r_vraw[31:13], r_addr[12:2], r_vraw[1:0]};
            model(r_we, r_addr, r_wd, r_hit, r_dirty, r_vraw, r_cline, r_fill, r_wbd, r_rfd);
            run_txn(r_we, r_addr, r_wd, r_hit, r_dirty, r_vraw, r_cline, r_fill, r_wbd, r_rfd, lat, rdata);
            compare($sformatf("rnd%0d", t), r_we, lat, rdata);
        end

        // Reset while a refill is outstanding.
        @(posedge clk); #1;
        c_hit = 1'b0; c_dirty = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0000_5000; cpu_req = 1'b1;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(posedge clk); #1;
            seen = mem_req;
        end
        chk("rr_refill_req", seen, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_b = 1'b0;
        #1;
        chk("rr_mem_req", mem_req, 1'b0);
        chk("rr_state", dbg_state, ST_IDLE);
        chk("rr_ready", cpu_ready, 1'b0);
        chk("rr_hits", perf_hits, 16'd0);
        chk("rr_misses", perf_misses, 16'd0);
        chk("rr_wbs", perf_wbs, 16'd0);
        #2;
        rst_b = 1'b1;
        m_hits = 16'd0; m_misses = 16'd0; m_wbs = 16'd0;
        model(1'b0, 32'h0000_6000, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hCAFE_F00D, 0, 1);
        run_txn(1'b0, 32'h0000_6000, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hCAFE_F00D, 0, 1, lat, rdata);
        compare("post_rst", 1'b0, lat, rdata);

        // cpu_req held high: three back-to-back hits.
        @(posedge clk); #1;
        c_hit = 1'b1; c_dirty = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0000_0040;
        c_rdata = 32'h5566_7788;
        cpu_req = 1'b1;
        n_rdy = 0;
        last  = -1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(posedge clk); #1;
            if (cpu_ready) begin
                n_rdy++;
                chk("b2b_rdata", cpu_rdata, 32'h5566_7788);
                if (last >= 0) chk("b2b_gap", cyc - last, 3);
                last = cyc;
                if (n_rdy == 3) cpu_req = 1'b0;
            end
        end
        cpu_req = 1'b0;
        chk("b2b_count", n_rdy, 3);
        chk("b2b_hits", perf_hits, m_hits + 16'd3);
        chk("b2b_state", dbg_state, ST_IDLE);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
